// File: rtl/lsu_wb.sv
// lsu_wb: load/store unit with register write-back.
//
// Accepts one memory access at a time from the EX/MEM stage, issues it on a
// simple req/gnt/rvalid bus, and for loads writes the extracted (and
// optionally sign-extended) data back to the register file.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   req_valid / req_ready       request handshake (ready only while idle)
//   req_access_type             access kind code (byte/half/word, load/store, other)
//   req_sign_ext                sign-extend narrow load data
//   req_addr / req_wdata        byte address / store data
//   req_rd                      load destination register
//   mem_req / mem_we            bus request / write flag
//   mem_addr / mem_be           word-aligned address / byte enables
//   mem_wdata                   lane-replicated store data
//   mem_gnt / mem_rvalid        bus grant / read data valid
//   mem_rdata                   read word
//   reg_wen / reg_waddr         register-file write enable / address
//   reg_wdata                   register-file write data
//   stall                       high whenever the unit is busy
//   misalign_err                one-cycle pulse after a rejected misaligned access

`ifndef MEM_ACCESS_TYPE_WIDTH
`define CPU_WIDTH                  32
`define REG_ADDR_WIDTH             5
`define MEM_ACCESS_TYPE_WIDTH      3
`define MEM_ACCESS_TYPE_NONE       3'd0
`define MEM_ACCESS_TYPE_READ_BYTE  3'd1
`define MEM_ACCESS_TYPE_READ_HALF  3'd2
`define MEM_ACCESS_TYPE_READ_WORD  3'd3
`define MEM_ACCESS_TYPE_WRITE_BYTE 3'd4
`define MEM_ACCESS_TYPE_WRITE_HALF 3'd5
`define MEM_ACCESS_TYPE_WRITE_WORD 3'd6
`endif

module lsu_wb (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [`MEM_ACCESS_TYPE_WIDTH-1:0] req_access_type,
  input  logic                              req_sign_ext,
  input  logic [`CPU_WIDTH-1:0]             req_addr,
  input  logic [`CPU_WIDTH-1:0]             req_wdata,
  input  logic [`REG_ADDR_WIDTH-1:0]        req_rd,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [`CPU_WIDTH-1:0]             mem_addr,
  output logic [3:0]                        mem_be,
  output logic [`CPU_WIDTH-1:0]             mem_wdata,
  input  logic                              mem_gnt,
  input  logic                              mem_rvalid,
  input  logic [`CPU_WIDTH-1:0]             mem_rdata,
  output logic                              reg_wen,
  output logic [`REG_ADDR_WIDTH-1:0]        reg_waddr,
  output logic [`CPU_WIDTH-1:0]             reg_wdata,
  output logic                              stall,
  output logic                              misalign_err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StWb   = 2'd3;

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic                       we_q;
  logic                       sign_q;
  logic [1:0]                 size_q;
  logic [`CPU_WIDTH-1:0]      addr_q;
  logic [`CPU_WIDTH-1:0]      wdata_q;
  logic [3:0]                 be_q;
  logic [`REG_ADDR_WIDTH-1:0] rd_q;
  logic [`CPU_WIDTH-1:0]      rdata_q;
  logic                       misalign_q;

  logic                       dec_mem;
  logic                       dec_store;
  logic [1:0]                 dec_size;
  logic                       dec_misalign;
  logic [3:0]                 dec_be;
  logic [`CPU_WIDTH-1:0]      dec_wdata;
  logic                       accept;
  logic                       start;
  logic [7:0]                 lane_b;
  logic [15:0]                lane_h;
  logic [`CPU_WIDTH-1:0]      load_data;

  // Request decode: kind, size, alignment, byte enables, replicated store data.
  always_comb begin
    dec_mem   = 1'b1;
    dec_store = 1'b0;
    dec_size  = SzWord;
    case (req_access_type)
      `MEM_ACCESS_TYPE_READ_BYTE:  dec_size = SzByte;
      `MEM_ACCESS_TYPE_READ_HALF:  dec_size = SzHalf;
      `MEM_ACCESS_TYPE_READ_WORD:  dec_size = SzWord;
      `MEM_ACCESS_TYPE_WRITE_BYTE: begin dec_store = 1'b1; dec_size = SzByte; end
      `MEM_ACCESS_TYPE_WRITE_HALF: begin dec_store = 1'b1; dec_size = SzHalf; end
      `MEM_ACCESS_TYPE_WRITE_WORD: begin dec_store = 1'b1; dec_size = SzWord; end
      default:                     dec_mem = 1'b0;
    endcase
  end

  always_comb begin
    dec_misalign = 1'b0;
    dec_be       = 4'b1111;
    dec_wdata    = req_wdata;
    case (dec_size)
      SzByte: begin
        dec_be    = 4'b0001 << req_addr[1:0];
        dec_wdata = {4{req_wdata[7:0]}};
      end
      SzHalf: begin
        dec_misalign = req_addr[0];
        dec_be       = req_addr[1] ? 4'b1100 : 4'b0011;
        dec_wdata    = {2{req_wdata[15:0]}};
      end
      default: dec_misalign = (req_addr[1:0] != 2'b00);
    endcase
  end

  assign accept = req_valid && (state_q == StIdle);
  assign start  = accept && dec_mem && !dec_misalign;

  // Load lane extraction uses the captured address offset.
  always_comb begin
    lane_b    = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h    = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (size_q)
      SzByte:  load_data = {{24{sign_q & lane_b[7]}}, lane_b};
      SzHalf:  load_data = {{16{sign_q & lane_h[15]}}, lane_h};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StReq;
      StReq:   if (mem_gnt) state_d = we_q ? StIdle : StWait;
      StWait:  if (mem_rvalid) state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      sign_q     <= 1'b0;
      size_q     <= SzByte;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 4'b0000;
      rd_q       <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= accept && dec_mem && dec_misalign;
      if (start) begin
        we_q    <= dec_store;
        sign_q  <= req_sign_ext;
        size_q  <= dec_size;
        addr_q  <= req_addr;
        wdata_q <= dec_store ? dec_wdata : '0;
        be_q    <= dec_be;
        rd_q    <= req_rd;
      end
      if (state_q == StWait && mem_rvalid) begin
        rdata_q <= load_data;
      end
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign stall        = (state_q != StIdle);
  assign mem_req      = (state_q == StReq);
  assign mem_we       = we_q;
  assign mem_addr     = {addr_q[31:2], 2'b00};
  assign mem_be       = be_q;
  assign mem_wdata    = wdata_q;
  // A load to x0 still goes to the bus but never writes the register file.
  assign reg_wen      = (state_q == StWb) && (rd_q != '0);
  assign reg_waddr    = rd_q;
  assign reg_wdata    = rdata_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_lsu_wb.sv
`ifndef MEM_ACCESS_TYPE_WIDTH
`define CPU_WIDTH                  32
`define REG_ADDR_WIDTH             5
`define MEM_ACCESS_TYPE_WIDTH      3
`define MEM_ACCESS_TYPE_NONE       3'd0
`define MEM_ACCESS_TYPE_READ_BYTE  3'd1
`define MEM_ACCESS_TYPE_READ_HALF  3'd2
`define MEM_ACCESS_TYPE_READ_WORD  3'd3
`define MEM_ACCESS_TYPE_WRITE_BYTE 3'd4
`define MEM_ACCESS_TYPE_WRITE_HALF 3'd5
`define MEM_ACCESS_TYPE_WRITE_WORD 3'd6
`endif

module tb_lsu_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_sign_ext;
  logic [2:0]  req_access_type;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        reg_wen, stall, misalign_err;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;

  always #5 clk = ~clk;

  lsu_wb dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_access_type(req_access_type), .req_sign_ext(req_sign_ext), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .reg_wen(reg_wen), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .stall(stall), .misalign_err(misalign_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_t;
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  bus_t bus_q[$];
  wb_t  wb_q[$];
  int   mis_pend = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  // Random-phase responder and driver state.
  bit          rd_pend = 1'b0;
  logic [31:0] rd_addr;
  int          rd_dly;
  bit          have = 1'b0;
  logic [2:0]  cty;
  logic        csx;
  logic [31:0] caddr, cwd;
  logic [4:0]  crd;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: what the bus and register file should see for one accepted request.
  task automatic push_expect(logic [2:0] ty, logic sx, logic [31:0] a, logic [31:0] wd,
                             logic [4:0] rd, logic [31:0] word);
    int          ity, size;
    bit          ld, st;
    bus_t        b;
    wb_t         w;
    logic [31:0] mask, val;
    ity = int'(ty);
    ld = (ity >= 1 && ity <= 3);
    st = (ity >= 4 && ity <= 6);
    if (!ld && !st) return;
    size = 1 << ((ity - 1) % 3);
    if ((a % size) != 0) begin
      mis_pend++;
      return;
    end
    b.addr  = a - (a % 4);
    b.be    = 4'(((1 << size) - 1) << (a % 4));
    b.we    = st;
    b.wdata = '0;
    for (int lane = 0; lane < 4; lane++) b.wdata[8*lane +: 8] = wd[8*(lane % size) +: 8];
    bus_q.push_back(b);
    if (ld && rd != 0) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
      val  = (word >> (8 * (a % 4))) & mask;
      if (sx && size < 4 && val[8*size-1]) val = val | ~mask;
      w.rd   = rd;
      w.data = val;
      wb_q.push_back(w);
    end
  endtask

  // Monitor: compares every bus request, register write and error pulse to the queues.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ready_vs_stall", 32'(req_ready), 32'(!stall));
      if (mem_req) begin
        if (bus_q.size() == 0) chk("bus_unexpected_req", 32'(mem_req), 0);
        else begin
          chk("bus_addr", mem_addr, bus_q[0].addr);
          chk("bus_be", 32'(mem_be), 32'(bus_q[0].be));
          chk("bus_we", 32'(mem_we), 32'(bus_q[0].we));
          if (bus_q[0].we) chk("bus_wdata", mem_wdata, bus_q[0].wdata);
          if (mem_gnt) void'(bus_q.pop_front());
        end
      end
      if (reg_wen) begin
        if (wb_q.size() == 0) chk("wb_unexpected", 32'(reg_wen), 0);
        else begin
          chk("wb_waddr", 32'(reg_waddr), 32'(wb_q[0].rd));
          chk("wb_wdata", reg_wdata, wb_q[0].data);
          void'(wb_q.pop_front());
        end
      end
      if (misalign_err) begin
        chk("misalign_unexpected", 32'(mis_pend == 0), 0);
        if (mis_pend > 0) mis_pend--;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_req(logic [2:0] ty, logic sx, logic [31:0] a, logic [31:0] wd,
                           logic [4:0] rd);
    req_valid       = 1'b1;
    req_access_type = ty;
    req_sign_ext    = sx;
    req_addr        = a;
    req_wdata       = wd;
    req_rd          = rd;
  endtask

  // One access with a hand-driven bus: gdly cycles of withheld grant, rvalid right after grant.
  task automatic directed(logic [2:0] ty, logic sx, logic [31:0] a, logic [31:0] wd,
                          logic [4:0] rd, int gdly, logic [31:0] rdata, logic [3:0] ebe,
                          logic [31:0] eval);
    logic [31:0] ea;
    bit          ld;
    ea = {a[31:2], 2'b00};
    ld = (ty >= 3'd1 && ty <= 3'd3);
    step();
    drive_req(ty, sx, a, wd, rd);
    push_expect(ty, sx, a, wd, rd, rdata);
    @(negedge clk);
    chk("d_accept_ready", 32'(req_ready), 1);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < gdly; i++) begin
      @(negedge clk);
      chk("d_hold_req", 32'(mem_req), 1);
      chk("d_hold_addr", mem_addr, ea);
      chk("d_hold_be", 32'(mem_be), 32'(ebe));
      if (!ld) chk("d_hold_wdata", mem_wdata, eval);
      step();
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("d_req", 32'(mem_req), 1);
    chk("d_addr", mem_addr, ea);
    chk("d_be", 32'(mem_be), 32'(ebe));
    chk("d_we", 32'(mem_we), 32'(!ld));
    if (!ld) chk("d_wdata", mem_wdata, eval);
    step();
    mem_gnt = 1'b0;
    if (ld) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      @(negedge clk);
      chk("d_wait_stall", 32'(stall), 1);
      chk("d_wait_noreq", 32'(mem_req), 0);
      step();
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      @(negedge clk);
      chk("d_wb_wen", 32'(reg_wen), 32'(rd != 0));
      if (rd != 0) begin
        chk("d_wb_waddr", 32'(reg_waddr), 32'(rd));
        chk("d_wb_wdata", reg_wdata, eval);
      end
      chk("d_wb_busy", 32'(req_ready), 0);
      step();
      @(negedge clk);
      chk("d_ld_done_ready", 32'(req_ready), 1);
      chk("d_ld_done_wen", 32'(reg_wen), 0);
    end else begin
      @(negedge clk);
      chk("d_st_done_ready", 32'(req_ready), 1);
      chk("d_st_no_wen", 32'(reg_wen), 0);
      chk("d_st_no_req", 32'(mem_req), 0);
    end
  endtask

  task automatic responder();
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (rd_pend) begin
      if (rd_dly == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(rd_addr);
        rd_pend    = 1'b0;
      end else rd_dly--;
    end else begin
      // Stray rvalid outside a pending read must be ignored.
      mem_rvalid = ($urandom_range(0, 7) == 0);
    end
    mem_gnt = 1'b0;
    if (mem_req && $urandom_range(0, 2) != 0) begin
      mem_gnt = 1'b1;
      if (!mem_we) begin
        rd_pend = 1'b1;
        rd_addr = mem_addr;
        rd_dly  = $urandom_range(0, 2);
      end
    end
  endtask

  task automatic driver(bit en);
    if (!have && en && $urandom_range(0, 2) == 0) begin
      have  = 1'b1;
      cty   = 3'($urandom_range(0, 7));
      csx   = 1'($urandom);
      caddr = $urandom & 32'h0000_0FFF;
      cwd   = $urandom;
      crd   = 5'($urandom_range(0, 31));
    end
    drive_req(cty, csx, caddr, cwd, crd);
    req_valid = have;
    // Held requests while busy check that nothing is taken until the unit is idle again.
    if (have && req_ready) begin
      push_expect(cty, csx, caddr, cwd, crd, mem_word(caddr & ~32'h3));
      have = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_access_type = '0; req_sign_ext = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    cty = '0; csx = 1'b0; caddr = '0; cwd = '0; crd = '0; rd_addr = '0; rd_dly = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", 32'(mem_be), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_reg_wen", 32'(reg_wen), 0);
    chk("rst_reg_waddr", 32'(reg_waddr), 0);
    chk("rst_reg_wdata", reg_wdata, 0);
    chk("rst_misalign", 32'(misalign_err), 0);
    step();
    rst = 1'b0;
    mon_en = 1'b1;

    directed(`MEM_ACCESS_TYPE_READ_WORD, 1'b0, 32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF,
             4'b1111, 32'hDEADBEEF);
    directed(`MEM_ACCESS_TYPE_READ_BYTE, 1'b1, 32'h103, 32'h0, 5'd9, 0, 32'h80112233,
             4'b1000, 32'hFFFFFF80);
    directed(`MEM_ACCESS_TYPE_READ_BYTE, 1'b0, 32'h103, 32'h0, 5'd9, 0, 32'h80112233,
             4'b1000, 32'h00000080);
    directed(`MEM_ACCESS_TYPE_WRITE_HALF, 1'b0, 32'h202, 32'h0000ABCD, 5'd0, 3, 32'h0,
             4'b1100, 32'hABCDABCD);
    directed(`MEM_ACCESS_TYPE_READ_HALF, 1'b1, 32'h10A, 32'h0, 5'd3, 1, 32'h80017FFF,
             4'b1100, 32'hFFFF8001);
    directed(`MEM_ACCESS_TYPE_WRITE_BYTE, 1'b0, 32'h31, 32'h123456C3, 5'd0, 0, 32'h0,
             4'b0010, 32'hC3C3C3C3);
    directed(`MEM_ACCESS_TYPE_READ_WORD, 1'b0, 32'h300, 32'h0, 5'd0, 1, 32'h11111111,
             4'b1111, 32'h0);

    // Misaligned word load is rejected with a single error pulse.
    step();
    drive_req(`MEM_ACCESS_TYPE_READ_WORD, 1'b0, 32'h101, 32'h0, 5'd4);
    push_expect(`MEM_ACCESS_TYPE_READ_WORD, 1'b0, 32'h101, 32'h0, 5'd4, 32'h0);
    @(negedge clk);
    chk("mis_pre_err", 32'(misalign_err), 0);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    chk("mis_err", 32'(misalign_err), 1);
    chk("mis_no_req", 32'(mem_req), 0);
    chk("mis_ready", 32'(req_ready), 1);
    step();
    @(negedge clk);
    chk("mis_err_one_cycle", 32'(misalign_err), 0);
    chk("mis_no_req2", 32'(mem_req), 0);
    chk("mis_no_wen", 32'(reg_wen), 0);

    // Reset while waiting for read data aborts the load; a late rvalid is ignored.
    step();
    drive_req(`MEM_ACCESS_TYPE_READ_WORD, 1'b0, 32'h40, 32'h0, 5'd7);
    push_expect(`MEM_ACCESS_TYPE_READ_WORD, 1'b0, 32'h40, 32'h0, 5'd0, 32'h0);
    @(negedge clk);
    step();
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    step();
    mem_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_stall", 32'(stall), 1);
    step();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 1);
    chk("abort_no_req", 32'(mem_req), 0);
    chk("abort_no_wen", 32'(reg_wen), 0);
    chk("abort_rdata_clr", reg_wdata, 0);
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("late_rvalid_no_wen", 32'(reg_wen), 0);
    chk("late_rvalid_ready", 32'(req_ready), 1);

    // Randomised traffic with a responder that varies grant and read latency.
    for (int c = 0; c < 4000; c++) begin
      step();
      responder();
      driver(c < 3900);
    end
    for (int c = 0; c < 100 && (have || rd_pend || bus_q.size() != 0 || wb_q.size() != 0
                                || mis_pend != 0); c++) begin
      step();
      responder();
      driver(1'b0);
    end
    step();
    req_valid = 1'b0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("drain_bus_q", 32'(bus_q.size()), 0);
    chk("drain_wb_q", 32'(wb_q.size()), 0);
    chk("drain_misalign", 32'(mis_pend), 0);
    chk("drain_ready", 32'(req_ready), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
